// File: rtl/lane_tx_serializer.sv
// Half-rate transmit serializer for one data lane: WIDTH-bit words in, two bits
// per clk out (even bit to DDR mux 'a', odd bit to 'b'), with a one-word skid buffer.
module lane_tx_serializer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_even,
    output logic             out_odd,
    output logic             out_valid,
    output logic             out_last,
    output logic             underflow
);

    localparam int BW = $clog2(WIDTH / 2);
    localparam logic [BW-1:0] LAST_BEAT = BW'(WIDTH / 2 - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] hold;
    logic [BW-1:0]    beat;
    logic             sr_last;
    logic             hold_last;
    logic             hold_valid;

    logic shifter_free;
    logic load_hold;
    logic load_direct;
    logic fill_hold;

    // A held word always wins over the live input so word order is preserved.
    assign shifter_free = (state == IDLE) || (beat == LAST_BEAT);
    assign load_hold    = shifter_free && hold_valid;
    assign load_direct  = shifter_free && !hold_valid && in_valid;
    assign fill_hold    = !shifter_free && in_valid && !hold_valid;
    assign in_ready     = !hold_valid && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (shifter_free) begin
            state_next = (load_hold || load_direct) ? SHIFT : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            beat       <= '0;
            sr_last    <= 1'b0;
            hold       <= '0;
            hold_last  <= 1'b0;
            hold_valid <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (load_hold) begin
                sr         <= hold;
                sr_last    <= hold_last;
                beat       <= '0;
                hold_valid <= 1'b0;
            end else if (load_direct) begin
                sr      <= in_data;
                sr_last <= in_last;
                beat    <= '0;
            end else if (shifter_free) begin
                // Running dry after a word not tagged last means the stream starved.
                sr   <= '0;
                beat <= '0;
                if (state == SHIFT && !sr_last) begin
                    underflow <= 1'b1;
                end
            end else begin
                sr   <= sr >> 2;
                beat <= beat + 1'b1;
            end

            if (fill_hold) begin
                hold       <= in_data;
                hold_last  <= in_last;
                hold_valid <= 1'b1;
            end
        end
    end

    assign out_even  = sr[0];
    assign out_odd   = sr[1];
    assign out_valid = (state == SHIFT);
    assign out_last  = (state == SHIFT) && sr_last && (beat == LAST_BEAT);

endmodule

// File: tb/tb_lane_tx_serializer.sv
// Self-checking bench for lane_tx_serializer (WIDTH=8): queue-based word model
// compared every cycle, plus hand-computed beat expectations per scenario.
module tb_lane_tx_serializer;

    localparam int W  = 8;
    localparam int NB = W / 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_even;
    logic         out_odd;
    logic         out_valid;
    logic         out_last;
    logic         underflow;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    lane_tx_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_even  (out_even),
        .out_odd   (out_odd),
        .out_valid (out_valid),
        .out_last  (out_last),
        .underflow (underflow)
    );

    // Model: words accepted in order; each occupies NB consecutive beats,
    // beat k carrying bits 2k and 2k+1. At most one word may wait behind the active one.
    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } word_t;

    word_t pend_q[$];
    word_t cur;
    word_t incoming;
    bit    m_active = 1'b0;
    int    m_beat   = 0;
    bit    m_uf     = 1'b0;
    bit    m_accept;

    always @(posedge clk) begin
        if (rst) begin
            pend_q.delete();
            m_active = 1'b0;
            m_beat   = 0;
            m_uf     = 1'b0;
        end else begin
            m_accept      = in_valid && (pend_q.size() == 0);
            incoming.data = in_data;
            incoming.last = in_last;
            if (m_active && m_beat < NB - 1) begin
                m_beat++;
                if (m_accept) pend_q.push_back(incoming);
            end else if (pend_q.size() > 0) begin
                cur      = pend_q.pop_front();
                m_active = 1'b1;
                m_beat   = 0;
            end else if (m_accept) begin
                cur      = incoming;
                m_active = 1'b1;
                m_beat   = 0;
            end else begin
                if (m_active && !cur.last) m_uf = 1'b1;
                m_active = 1'b0;
            end
        end
    end

    task automatic compare(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%b exp=%b t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare("model_valid", out_valid, m_active);
            compare("model_even", out_even, m_active ? cur.data[2*m_beat] : 1'b0);
            compare("model_odd", out_odd, m_active ? cur.data[2*m_beat+1] : 1'b0);
            compare("model_last", out_last, m_active && cur.last && (m_beat == NB - 1));
            compare("model_ready", in_ready, !rst && (pend_q.size() == 0));
            compare("model_underflow", underflow, m_uf);
        end
    end

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        rst      = r;
        @(posedge clk);
        #2;
    endtask

    // Expected vector order: {even, odd, valid, last, ready, underflow}.
    task automatic checkOutput(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {out_even, out_odd, out_valid, out_last, in_ready, underflow};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%b exp=%b t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_state", 6'b000000);
        chk_en = 1'b1;
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("post_reset_idle", 6'b000010);

        $display("[TB] scenario 1: single word B4 tagged last");
        applyStimulus(1, 8'hB4, 1, 0); checkOutput("s1_beat0", 6'b001010);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s1_beat1", 6'b101010);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s1_beat2", 6'b111010);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s1_beat3", 6'b011110);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s1_idle", 6'b000010);

        $display("[TB] scenario 2: back-to-back FF then 00");
        applyStimulus(1, 8'hFF, 0, 0); checkOutput("s2_ff_beat0", 6'b111010);
        applyStimulus(1, 8'h00, 1, 0); checkOutput("s2_ff_beat1", 6'b111000);
        for (int i = 2; i < NB; i++) begin
            applyStimulus(0, 8'h00, 0, 0); checkOutput("s2_ff_beat_hold", 6'b111000);
        end
        for (int i = 0; i < NB - 1; i++) begin
            applyStimulus(0, 8'h00, 0, 0); checkOutput("s2_00_beat", 6'b001010);
        end
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s2_00_beat3", 6'b001110);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s2_idle", 6'b000010);

        $display("[TB] scenario 3: untagged AA then starvation");
        for (int i = 0; i < NB; i++) begin
            applyStimulus(i == 0, 8'hAA, 0, 0); checkOutput("s3_aa_beat", 6'b011010);
        end
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s3_underflow", 6'b000011);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 8'h00, 0, 0); checkOutput("s3_underflow_sticky", 6'b000011);
        end
        applyStimulus(0, 8'h00, 0, 1); checkOutput("s3_reset", 6'b000000);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s3_after_reset", 6'b000010);

        $display("[TB] scenario 4: reset mid-word with held word");
        applyStimulus(1, 8'hF0, 0, 0); checkOutput("s4_f0_beat0", 6'b001010);
        applyStimulus(1, 8'h55, 1, 0); checkOutput("s4_f0_beat1", 6'b001000);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s4_f0_beat2", 6'b111000);
        applyStimulus(0, 8'h00, 0, 1); checkOutput("s4_reset", 6'b000000);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s4_hold_cleared", 6'b000010);
        applyStimulus(1, 8'h0C, 1, 0); checkOutput("s4_0c_beat0", 6'b001010);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s4_0c_beat1", 6'b111010);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s4_0c_beat2", 6'b001010);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s4_0c_beat3", 6'b001110);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s4_idle", 6'b000010);

        $display("[TB] scenario 5: direct load on last beat");
        applyStimulus(1, 8'h3C, 0, 0); checkOutput("s5_3c_beat0", 6'b001010);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s5_3c_beat1", 6'b111010);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s5_3c_beat2", 6'b111010);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s5_3c_beat3", 6'b001010);
        applyStimulus(1, 8'h0F, 1, 0); checkOutput("s5_0f_beat0", 6'b111010);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s5_0f_beat1", 6'b111010);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s5_0f_beat2", 6'b001010);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s5_0f_beat3", 6'b001110);
        applyStimulus(0, 8'h00, 0, 0); checkOutput("s5_idle", 6'b000010);

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
